// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and stage state encoding, used by the
// radix-2 SDF stages and the downstream twiddle multiplier.
package fft_pkg;

   localparam int FFT_WORD_LENGTH  = 16;
   localparam int FFT_INT_LENGTH   = 0;
   localparam int FFT_FLOAT_LENGTH = 15;
   localparam int FFT_DEPTH        = 8;
   localparam int FFT_IDX_WIDTH    = 3;

   typedef enum logic [1:0] {
      ST_FILL    = 2'd0,
      ST_PHASE_A = 2'd1,
      ST_PHASE_B = 2'd2
   } sdf_state_e;

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Enable-shifted feedback delay line of an SDF stage; head_o is the oldest entry.
module sdf_delay_line
   import fft_pkg::*;
#(
   parameter int WIDTH = 2 * (FFT_WORD_LENGTH + 1),
   parameter int DEPTH = FFT_DEPTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // shift one position per accepted sample, newest at index 0
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < DEPTH; k++) begin
            mem_q[k] <= '0;
         end
      end else if (en_i) begin
         mem_q[0] <= din_i;
         for (int k = 1; k < DEPTH; k++) begin
            mem_q[k] <= mem_q[k-1];
         end
      end
   end

   assign head_o = mem_q[DEPTH-1];

endmodule

// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: emits sums then twiddle-indexed
// differences of samples N/2 apart, one registered sample per accepted input.
module r2sdf_stage
   import fft_pkg::*;
#(
   parameter int WORD_LENGTH  = FFT_WORD_LENGTH,
   parameter int INT_LENGTH   = FFT_INT_LENGTH,
   parameter int FLOAT_LENGTH = FFT_FLOAT_LENGTH,
   parameter int DEPTH        = FFT_DEPTH,
   parameter int IDX_WIDTH    = FFT_IDX_WIDTH
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         clr,
   input  logic                         in_valid,
   input  logic signed [WORD_LENGTH-1:0] in_i,
   input  logic signed [WORD_LENGTH-1:0] in_q,
   output logic                         out_valid,
   output logic signed [WORD_LENGTH:0]  out_i,
   output logic signed [WORD_LENGTH:0]  out_q,
   output logic                         out_diff,
   output logic [IDX_WIDTH-1:0]         tw_idx
);

   localparam int OW = WORD_LENGTH + 1;
   localparam int CW = IDX_WIDTH + 1;

   if ((WORD_LENGTH != INT_LENGTH + FLOAT_LENGTH + 1) ||
       !is_pow2(DEPTH) || (DEPTH != (1 << IDX_WIDTH))) begin : g_param_check
      $error("r2sdf_stage: inconsistent word format or DEPTH/IDX_WIDTH");
   end

   sdf_state_e          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                out_valid_q, out_valid_d;
   logic signed [OW-1:0] out_i_q, out_i_d;
   logic signed [OW-1:0] out_q_q, out_q_d;
   logic                out_diff_q, out_diff_d;
   logic [IDX_WIDTH-1:0] tw_idx_q, tw_idx_d;

   logic                accept_s;
   logic                phase_b_s;
   logic                primed_s;
   logic                last_a_s;
   logic                last_b_s;
   logic signed [OW-1:0] in_i_ext_s, in_q_ext_s;
   logic signed [OW-1:0] head_i_s, head_q_s;
   logic signed [OW-1:0] sum_i_s, sum_q_s;
   logic signed [OW-1:0] diff_i_s, diff_q_s;
   logic [2*OW-1:0]     push_s;
   logic [2*OW-1:0]     head_s;

   // clr wins over a simultaneous sample, so nothing is accepted on a clear cycle
   assign accept_s  = in_valid & ~clr;
   assign phase_b_s = cnt_q[IDX_WIDTH];
   assign primed_s  = (state_q != ST_FILL);
   assign last_a_s  = (cnt_q == CW'(DEPTH - 1));
   assign last_b_s  = (cnt_q == CW'(2 * DEPTH - 1));

   assign in_i_ext_s = {in_i[WORD_LENGTH-1], in_i};
   assign in_q_ext_s = {in_q[WORD_LENGTH-1], in_q};
   assign head_i_s   = head_s[2*OW-1:OW];
   assign head_q_s   = head_s[OW-1:0];
   assign sum_i_s    = head_i_s + in_i_ext_s;
   assign sum_q_s    = head_q_s + in_q_ext_s;
   assign diff_i_s   = head_i_s - in_i_ext_s;
   assign diff_q_s   = head_q_s - in_q_ext_s;
   assign push_s     = phase_b_s ? {diff_i_s, diff_q_s} : {in_i_ext_s, in_q_ext_s};

   sdf_delay_line #(
      .WIDTH (2 * OW),
      .DEPTH (DEPTH)
   ) u_delay_line (
      .clk_i  (CLK),
      .rst_ni (RST),
      .en_i   (accept_s),
      .din_i  (push_s),
      .head_o (head_s)
   );

   // next state and sample counter; counter wraps naturally at 2*DEPTH
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clr) begin
         state_d = ST_FILL;
         cnt_d   = '0;
      end else if (accept_s) begin
         cnt_d = cnt_q + {{IDX_WIDTH{1'b0}}, 1'b1};
         case (state_q)
            ST_FILL: begin
               if (last_a_s) begin
                  state_d = ST_PHASE_B;
               end else begin
                  state_d = ST_FILL;
               end
            end
            ST_PHASE_A: begin
               if (last_a_s) begin
                  state_d = ST_PHASE_B;
               end else begin
                  state_d = ST_PHASE_A;
               end
            end
            ST_PHASE_B: begin
               if (last_b_s) begin
                  state_d = ST_PHASE_A;
               end else begin
                  state_d = ST_PHASE_B;
               end
            end
            default: begin
               state_d = ST_FILL;
            end
         endcase
      end else begin
         state_d = state_q;
         cnt_d   = cnt_q;
      end
   end

   // output sample selection; data outputs hold when nothing is accepted
   always_comb begin
      out_valid_d = 1'b0;
      out_i_d     = out_i_q;
      out_q_d     = out_q_q;
      out_diff_d  = out_diff_q;
      tw_idx_d    = tw_idx_q;
      if (accept_s) begin
         out_valid_d = primed_s;
         if (phase_b_s) begin
            out_i_d    = sum_i_s;
            out_q_d    = sum_q_s;
            out_diff_d = 1'b0;
            tw_idx_d   = '0;
         end else begin
            out_i_d    = head_i_s;
            out_q_d    = head_q_s;
            out_diff_d = 1'b1;
            tw_idx_d   = cnt_q[IDX_WIDTH-1:0];
         end
      end else begin
         out_valid_d = 1'b0;
      end
   end

   // control and output registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_FILL;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_i_q     <= '0;
         out_q_q     <= '0;
         out_diff_q  <= 1'b0;
         tw_idx_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_i_q     <= out_i_d;
         out_q_q     <= out_q_d;
         out_diff_q  <= out_diff_d;
         tw_idx_q    <= tw_idx_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_i     = out_i_q;
   assign out_q     = out_q_q;
   assign out_diff  = out_diff_q;
   assign tw_idx    = tw_idx_q;

endmodule

// File: tb/tb_r2sdf_stage.sv
// Directed self-checking bench for r2sdf_stage with hand-derived butterfly results.
module tb_r2sdf_stage;

   logic               CLK = 1'b0;
   logic               RST = 1'b0;
   logic               clr = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [15:0] in_i = '0;
   logic signed [15:0] in_q = '0;
   logic               out_valid;
   logic signed [16:0] out_i;
   logic signed [16:0] out_q;
   logic               out_diff;
   logic [2:0]         tw_idx;

   int checks_r = 0;
   int errors_r = 0;

   r2sdf_stage dut (
      .CLK       (CLK),
      .RST       (RST),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_i      (in_i),
      .in_q      (in_q),
      .out_valid (out_valid),
      .out_i     (out_i),
      .out_q     (out_q),
      .out_diff  (out_diff),
      .tw_idx    (tw_idx)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
      checks_r++;
      if (got !== exp) begin
         errors_r++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input int di, input int dq, input logic c);
      @(negedge CLK);
      in_valid = v;
      in_i     = di[15:0];
      in_q     = dq[15:0];
      clr      = c;
      @(posedge CLK);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_i"},     out_i,     0);
      chk({tag, "_q"},     out_q,     0);
      chk({tag, "_diff"},  out_diff,  0);
      chk({tag, "_tw"},    tw_idx,    0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      in_valid = 1'b0;
      clr      = 1'b0;
      RST      = 1'b0;
      #2;
      check_reset_outputs("rst");
      @(negedge CLK);
      RST = 1'b1;
   endtask

   // ramp n*256 on I: sums (2n-8)*256 in the second half, then -2048 differences
   task automatic run_ramp(input bit gaps);
      int last_i;
      last_i = 0;
      for (int n = 0; n < 16; n++) begin
         drive(1'b1, n * 256, 0, 1'b0);
         if (n < 8) begin
            chk("fill_valid", out_valid, 0);
         end else begin
            last_i = (2 * n - 8) * 256;
            chk("sum_valid", out_valid, 1);
            chk("sum_i",     out_i,     last_i);
            chk("sum_q",     out_q,     0);
            chk("sum_diff",  out_diff,  0);
            chk("sum_tw",    tw_idx,    0);
         end
         if (gaps) begin
            drive(1'b0, 12345, 777, 1'b0);
            chk("gap_valid", out_valid, 0);
            if (n >= 8) chk("gap_hold", out_i, last_i);
         end
      end
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 0, 0, 1'b0);
         chk("dif_valid", out_valid, 1);
         chk("dif_i",     out_i,     -2048);
         chk("dif_q",     out_q,     0);
         chk("dif_diff",  out_diff,  1);
         chk("dif_tw",    tw_idx,    k);
         if (gaps) begin
            drive(1'b0, 999, 999, 1'b0);
            chk("gap_valid", out_valid, 0);
            chk("gap_hold",  out_i,     -2048);
         end
      end
   endtask

   initial begin
      // basic ramp from reset
      do_reset();
      run_ramp(1'b0);

      // most negative input on both rails: sums need the extra bit
      do_reset();
      for (int n = 0; n < 24; n++) begin
         drive(1'b1, -32768, -32768, 1'b0);
         if (n < 8) begin
            chk("neg_fill", out_valid, 0);
         end else if (n < 16) begin
            chk("neg_valid", out_valid, 1);
            chk("neg_sum_i", out_i, -65536);
            chk("neg_sum_q", out_q, -65536);
         end else begin
            chk("neg_valid", out_valid, 1);
            chk("neg_dif_i", out_i, 0);
            chk("neg_dif_q", out_q, 0);
            chk("neg_tw",    tw_idx, n - 16);
         end
      end

      // same ramp with idle cycles interleaved
      do_reset();
      run_ramp(1'b1);

      // clear mid-block together with a valid sample, then replay
      do_reset();
      for (int n = 0; n < 11; n++) begin
         drive(1'b1, n * 256, 0, 1'b0);
      end
      chk("pre_clr_i", out_i, 2 * 256 * 10 - 2048);
      drive(1'b1, 4096, 4096, 1'b1);
      chk("clr_valid", out_valid, 0);
      run_ramp(1'b0);

      // asynchronous reset in the middle of a block
      do_reset();
      for (int n = 0; n < 16; n++) begin
         drive(1'b1, n * 256, 0, 1'b0);
      end
      for (int n = 0; n < 5; n++) begin
         drive(1'b1, 0, 0, 1'b0);
      end
      chk("pre_rst_valid", out_valid, 1);
      #2;
      RST = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge CLK);
      in_valid = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      run_ramp(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
      $finish;
   end

endmodule
